// File: rtl/riscv_types.sv
// Shared types for the ALU issue stage.
// Holds the datapath width, the register address type, the operand-select
// enums, the decoded-op and ALU-input bundles, and a helper that turns a
// register address into a one-hot scoreboard mask.
package riscv_types;

    localparam int XLEN = 32;

    typedef logic [4:0] rs_addr_t;

    typedef enum logic [1:0] {
        SRC1_RS1  = 2'd0,
        SRC1_PC   = 2'd1,
        SRC1_ZERO = 2'd2
    } src1_sel_t;

    typedef enum logic {
        SRC2_RS2 = 1'b0,
        SRC2_IMM = 1'b1
    } src2_sel_t;

    typedef enum logic [1:0] {
        LOGIC_XOR  = 2'd0,
        LOGIC_OR   = 2'd1,
        LOGIC_AND  = 2'd2,
        LOGIC_NONE = 2'd3
    } alu_logic_op_t;

    typedef struct packed {
        rs_addr_t      rs1_addr;
        rs_addr_t      rs2_addr;
        rs_addr_t      rd_addr;
        logic          rd_en;
        src1_sel_t     src1_sel;
        src2_sel_t     src2_sel;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic          is_unsigned;
        logic          subtract;
        logic          arith;
        logic          lshift;
        logic          shifter_path;
        logic          slt_path;
        alu_logic_op_t logic_op;
    } alu_dec_t;

    typedef struct packed {
        logic [XLEN:0]   in1;
        logic [XLEN:0]   in2;
        logic [XLEN-1:0] shifter_in;
        logic [4:0]      shift_amount;
        logic            subtract;
        logic            arith;
        logic            lshift;
        logic            shifter_path;
        logic            slt_path;
        alu_logic_op_t   logic_op;
    } alu_inputs_t;

    // One-hot mask selecting the scoreboard bit of a register.
    function automatic logic [31:0] addr_onehot(input rs_addr_t addr);
        return 32'h0000_0001 << addr;
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Bus bundle between the decoder, the issue stage, the ALU and writeback.
//   dec_*    : decoded-op handshake into the issue stage
//   issue_*  : operand bundle and destination handshake out to the ALU
//   wb_*     : ALU result writeback into the register file
//   flush    : discard the op held in the issue register
// slave is the issue stage's view, master is the surrounding pipeline's view.
interface alu_issue_if;
    import riscv_types::*;

    logic            dec_valid;
    logic            dec_ready;
    alu_dec_t        dec_op;
    logic            issue_valid;
    logic            issue_ready;
    alu_inputs_t     alu_inputs;
    rs_addr_t        issue_rd_addr;
    logic            issue_rd_en;
    logic            wb_en;
    rs_addr_t        wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            flush;

    modport slave (
        input  dec_valid, dec_op, issue_ready, wb_en, wb_addr, wb_data, flush,
        output dec_ready, issue_valid, alu_inputs, issue_rd_addr, issue_rd_en
    );

    modport master (
        output dec_valid, dec_op, issue_ready, wb_en, wb_addr, wb_data, flush,
        input  dec_ready, issue_valid, alu_inputs, issue_rd_addr, issue_rd_en
    );

endinterface

// File: rtl/alu_issue_reg_file.sv
// 32-entry integer register file: two asynchronous read ports, one
// synchronous write port, x0 hardwired to zero.
//   clk, rst     : clock and synchronous active-high reset (clears all entries)
//   ra1/ra2      : read addresses, rd1/rd2 read data
//   we, wa, wd   : write enable, address and data
module reg_file_2r1w
    import riscv_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  rs_addr_t        ra1,
    input  rs_addr_t        ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  rs_addr_t        wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] regs_r [32];

    // Register storage: cleared on reset, x0 never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= '0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs_r[wa] <= wd;
        end else begin
            regs_r <= regs_r;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? '0 : regs_r[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : regs_r[ra2];

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: reads operands (with writeback bypass), tracks pending
// destinations in a scoreboard, and holds one op in a registered issue slot.
//   clk, rst : clock and synchronous active-high reset
//   bus      : alu_issue_if.slave (dec_*, issue_*, alu_inputs, wb_*, flush)
module alu_issue
    import riscv_types::*;
#(
    parameter int XLEN = riscv_types::XLEN
) (
    input  logic        clk,
    input  logic        rst,
    alu_issue_if.slave  bus
);

    alu_dec_t        op_s;
    logic [XLEN-1:0] rs1_rf_s, rs2_rf_s;
    logic [XLEN-1:0] rs1_val_s, rs2_val_s;
    logic [XLEN-1:0] src1_s, src2_s;
    logic [31:0]     sb_r, sb_next_s, live_s;
    logic [31:0]     wb_clr_s, flush_clr_s, set_s;
    logic            hazard_s, blocked_s, dec_ready_s, accept_s, flush_held_s;
    alu_inputs_t     ai_next_s, ai_r;
    logic            issue_valid_r, issue_rd_en_r;
    rs_addr_t        issue_rd_addr_r;

    assign op_s = bus.dec_op;

    reg_file_2r1w #(.XLEN(XLEN)) u_rf (
        .clk (clk),
        .rst (rst),
        .ra1 (op_s.rs1_addr),
        .ra2 (op_s.rs2_addr),
        .rd1 (rs1_rf_s),
        .rd2 (rs2_rf_s),
        .we  (bus.wb_en),
        .wa  (bus.wb_addr),
        .wd  (bus.wb_data)
    );

    // Source values, forwarding a same-cycle writeback to a matching non-x0 read.
    always_comb begin
        rs1_val_s = rs1_rf_s;
        rs2_val_s = rs2_rf_s;
        if (bus.wb_en && (bus.wb_addr == op_s.rs1_addr) && (op_s.rs1_addr != 5'd0)) begin
            rs1_val_s = bus.wb_data;
        end else begin
            rs1_val_s = rs1_rf_s;
        end
        if (bus.wb_en && (bus.wb_addr == op_s.rs2_addr) && (op_s.rs2_addr != 5'd0)) begin
            rs2_val_s = bus.wb_data;
        end else begin
            rs2_val_s = rs2_rf_s;
        end
    end

    // A writeback this cycle already satisfies its dependents, so it is masked
    // out before the hazard check.
    assign wb_clr_s = bus.wb_en ? addr_onehot(bus.wb_addr) : 32'd0;
    assign live_s   = sb_r & ~wb_clr_s;

    assign hazard_s = ((op_s.src1_sel == SRC1_RS1) && live_s[op_s.rs1_addr]) ||
                      ((op_s.src2_sel == SRC2_RS2) && live_s[op_s.rs2_addr]) ||
                      (op_s.rd_en && live_s[op_s.rd_addr]);
    assign blocked_s   = issue_valid_r && !bus.issue_ready;
    assign dec_ready_s = !rst && !bus.flush && !hazard_s && !blocked_s;
    assign accept_s    = bus.dec_valid && dec_ready_s;

    // Flush only discards an op that is not leaving through a handshake.
    assign flush_held_s = bus.flush && issue_valid_r && !bus.issue_ready;
    assign flush_clr_s  = (flush_held_s && issue_rd_en_r) ? addr_onehot(issue_rd_addr_r) : 32'd0;
    assign set_s        = (accept_s && op_s.rd_en && (op_s.rd_addr != 5'd0)) ?
                          addr_onehot(op_s.rd_addr) : 32'd0;
    // Set after clear so a same-cycle set of a bit wins; bit 0 is never pending.
    assign sb_next_s    = ((sb_r & ~wb_clr_s & ~flush_clr_s) | set_s) & ~32'd1;

    // Operand selection and ALU input bundle for the op being accepted.
    always_comb begin
        src1_s    = '0;
        src2_s    = '0;
        ai_next_s = '0;
        case (op_s.src1_sel)
            SRC1_RS1:  src1_s = rs1_val_s;
            SRC1_PC:   src1_s = op_s.pc;
            SRC1_ZERO: src1_s = '0;
            default:   src1_s = '0;
        endcase
        case (op_s.src2_sel)
            SRC2_RS2: src2_s = rs2_val_s;
            SRC2_IMM: src2_s = op_s.imm;
            default:  src2_s = op_s.imm;
        endcase
        ai_next_s.in1          = {(op_s.is_unsigned ? 1'b0 : src1_s[XLEN-1]), src1_s};
        ai_next_s.in2          = {(op_s.is_unsigned ? 1'b0 : src2_s[XLEN-1]), src2_s};
        ai_next_s.shifter_in   = rs1_val_s;
        ai_next_s.shift_amount = src2_s[4:0];
        ai_next_s.subtract     = op_s.subtract;
        ai_next_s.arith        = op_s.arith;
        ai_next_s.lshift       = op_s.lshift;
        ai_next_s.shifter_path = op_s.shifter_path;
        ai_next_s.slt_path     = op_s.slt_path;
        ai_next_s.logic_op     = op_s.logic_op;
    end

    // Pending-destination scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_r <= 32'd0;
        end else begin
            sb_r <= sb_next_s;
        end
    end

    // One-deep issue register; payload only changes on accept so it stays
    // stable while the ALU back-pressures.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid_r   <= 1'b0;
            ai_r            <= '0;
            issue_rd_addr_r <= 5'd0;
            issue_rd_en_r   <= 1'b0;
        end else if (accept_s) begin
            issue_valid_r   <= 1'b1;
            ai_r            <= ai_next_s;
            issue_rd_addr_r <= op_s.rd_addr;
            issue_rd_en_r   <= op_s.rd_en;
        end else if (bus.flush || bus.issue_ready) begin
            issue_valid_r   <= 1'b0;
        end else begin
            issue_valid_r   <= issue_valid_r;
        end
    end

    assign bus.dec_ready     = dec_ready_s;
    assign bus.issue_valid   = issue_valid_r;
    assign bus.alu_inputs    = ai_r;
    assign bus.issue_rd_addr = issue_rd_addr_r;
    assign bus.issue_rd_en   = issue_rd_en_r;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: a table of operand-build vectors, hand-written
// sequences for stalls, back-pressure, x0, flush and reset, and a scoreboard
// queue that predicts every issued bundle from a register model.
module tb_alu_issue;
    import riscv_types::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_issue_if bus ();

    alu_issue dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        alu_inputs_t ai;
        rs_addr_t    rd;
        logic        rd_en;
    } exp_t;

    typedef struct {
        rs_addr_t    rs1;
        rs_addr_t    rs2;
        src1_sel_t   s1;
        src2_sel_t   s2;
        logic [31:0] imm;
        logic        uns;
        logic [32:0] e_in1;
        logic [32:0] e_in2;
        logic [4:0]  e_sh;
        logic [31:0] e_shin;
    } vec_t;

    exp_t        exp_q[$];
    logic [31:0] model [32];
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic alu_dec_t mk_op(input rs_addr_t rs1, input rs_addr_t rs2, input rs_addr_t rd,
                                       input logic rd_en, input src1_sel_t s1, input src2_sel_t s2,
                                       input logic [31:0] imm, input logic uns);
        alu_dec_t op;
        op = '0;
        op.rs1_addr = rs1;
        op.rs2_addr = rs2;
        op.rd_addr = rd;
        op.rd_en = rd_en;
        op.src1_sel = s1;
        op.src2_sel = s2;
        op.imm = imm;
        op.pc = 32'h0000_1000;
        op.is_unsigned = uns;
        op.logic_op = LOGIC_NONE;
        return op;
    endfunction

    // Reference operand bundle from source values a (rs1) and b (rs2).
    function automatic alu_inputs_t predict(input alu_dec_t op, input logic [31:0] a, input logic [31:0] b);
        alu_inputs_t ai;
        logic [31:0] x, y;
        ai = '0;
        x = (op.src1_sel == SRC1_RS1) ? a : ((op.src1_sel == SRC1_PC) ? op.pc : 32'd0);
        y = (op.src2_sel == SRC2_RS2) ? b : op.imm;
        ai.in1 = op.is_unsigned ? {1'b0, x} : {x[31], x};
        ai.in2 = op.is_unsigned ? {1'b0, y} : {y[31], y};
        ai.shifter_in = a;
        ai.shift_amount = y[4:0];
        ai.subtract = op.subtract;
        ai.arith = op.arith;
        ai.lshift = op.lshift;
        ai.shifter_path = op.shifter_path;
        ai.slt_path = op.slt_path;
        ai.logic_op = op.logic_op;
        return ai;
    endfunction

    // Scoreboard: push on decode handshake, pop on issue handshake or flush.
    task automatic monitor();
        exp_t e;
        logic [31:0] a, b;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                for (int i = 0; i < 32; i++) model[i] = 32'd0;
            end else begin
                if (bus.issue_valid && bus.issue_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_issue", 128'd1, 128'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_alu_inputs", bus.alu_inputs, e.ai);
                        chk("sb_rd_addr", bus.issue_rd_addr, e.rd);
                        chk("sb_rd_en", bus.issue_rd_en, e.rd_en);
                    end
                end else if (bus.flush && bus.issue_valid && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                end
                if (bus.dec_valid && bus.dec_ready) begin
                    a = model[bus.dec_op.rs1_addr];
                    b = model[bus.dec_op.rs2_addr];
                    if (bus.wb_en && bus.wb_addr != 5'd0 && bus.wb_addr == bus.dec_op.rs1_addr) a = bus.wb_data;
                    if (bus.wb_en && bus.wb_addr != 5'd0 && bus.wb_addr == bus.dec_op.rs2_addr) b = bus.wb_data;
                    e.ai = predict(bus.dec_op, a, b);
                    e.rd = bus.dec_op.rd_addr;
                    e.rd_en = bus.dec_op.rd_en;
                    exp_q.push_back(e);
                end
                if (bus.wb_en && bus.wb_addr != 5'd0) model[bus.wb_addr] = bus.wb_data;
            end
        end
    endtask

    task automatic wb_write(input rs_addr_t addr, input logic [31:0] data);
        bus.wb_en = 1'b1;
        bus.wb_addr = addr;
        bus.wb_data = data;
        tick();
        bus.wb_en = 1'b0;
    endtask

    task automatic send(input alu_dec_t op);
        logic got;
        got = 1'b0;
        bus.dec_valid = 1'b1;
        bus.dec_op = op;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.dec_ready) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        tick();
        bus.dec_valid = 1'b0;
        chk("accept_in_budget", got, 1'b1);
    endtask

    task automatic wait_issue(output alu_inputs_t ai, output int lat);
        logic got;
        got = 1'b0;
        lat = 0;
        ai = '0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.issue_valid && bus.issue_ready) begin
                ai = bus.alu_inputs;
                got = 1'b1;
                break;
            end
            lat++;
            tick();
        end
        tick();
        chk("issue_in_budget", got, 1'b1);
    endtask

    initial begin
        vec_t        vecs[6];
        alu_inputs_t ai, snap;
        rs_addr_t    snap_rd;
        int          lat;
        logic [1:0]  lo;

        vecs[0] = '{5'd10, 5'd11, SRC1_RS1,  SRC2_RS2, 32'h0000_0000, 1'b0, 33'h0_0000_00FF, 33'h1_FFFF_FFF0, 5'h10, 32'h0000_00FF};
        vecs[1] = '{5'd10, 5'd11, SRC1_RS1,  SRC2_RS2, 32'h0000_0000, 1'b1, 33'h0_0000_00FF, 33'h0_FFFF_FFF0, 5'h10, 32'h0000_00FF};
        vecs[2] = '{5'd10, 5'd0,  SRC1_PC,   SRC2_IMM, 32'h0000_0004, 1'b0, 33'h0_0000_1000, 33'h0_0000_0004, 5'h04, 32'h0000_00FF};
        vecs[3] = '{5'd0,  5'd0,  SRC1_ZERO, SRC2_IMM, 32'h8000_0000, 1'b0, 33'h0_0000_0000, 33'h1_8000_0000, 5'h00, 32'h0000_0000};
        vecs[4] = '{5'd11, 5'd0,  SRC1_RS1,  SRC2_IMM, 32'h0000_0023, 1'b1, 33'h0_FFFF_FFF0, 33'h0_0000_0023, 5'h03, 32'hFFFF_FFF0};
        vecs[5] = '{5'd11, 5'd0,  SRC1_RS1,  SRC2_IMM, 32'h0000_0023, 1'b0, 33'h1_FFFF_FFF0, 33'h0_0000_0023, 5'h03, 32'hFFFF_FFF0};

        rst = 1'b1;
        bus.dec_valid = 1'b1;
        bus.dec_op = '0;
        bus.issue_ready = 1'b1;
        bus.wb_en = 1'b0;
        bus.wb_addr = 5'd0;
        bus.wb_data = 32'd0;
        bus.flush = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        tick();
        tick();
        @(negedge clk);
        chk("rst_issue_valid", bus.issue_valid, 1'b0);
        chk("rst_dec_ready", bus.dec_ready, 1'b0);
        chk("rst_alu_inputs", bus.alu_inputs, 128'd0);
        tick();
        rst = 1'b0;
        bus.dec_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", bus.dec_ready, 1'b1);
        tick();

        // Signed extension of a negative register plus immediate
        wb_write(5'd5, 32'h8000_0000);
        send(mk_op(5'd5, 5'd0, 5'd6, 1'b1, SRC1_RS1, SRC2_IMM, 32'd1, 1'b0));
        wait_issue(ai, lat);
        chk("add_latency", lat, 0);
        chk("add_in1", ai.in1, 33'h1_8000_0000);
        chk("add_in2", ai.in2, 33'h0_0000_0001);
        wb_write(5'd6, 32'h8000_0001);

        // Operand-build vectors
        wb_write(5'd10, 32'h0000_00FF);
        wb_write(5'd11, 32'hFFFF_FFF0);
        for (int i = 0; i < 6; i++) begin
            alu_dec_t op;
            op = mk_op(vecs[i].rs1, vecs[i].rs2, 5'd0, 1'b0, vecs[i].s1, vecs[i].s2, vecs[i].imm, vecs[i].uns);
            lo = i[1:0];
            op.subtract = lo[0];
            op.logic_op = alu_logic_op_t'(lo);
            send(op);
            wait_issue(ai, lat);
            chk("vec_in1", ai.in1, vecs[i].e_in1);
            chk("vec_in2", ai.in2, vecs[i].e_in2);
            chk("vec_shamt", ai.shift_amount, vecs[i].e_sh);
            chk("vec_shin", ai.shifter_in, vecs[i].e_shin);
        end

        // RAW stall, released by writeback with bypass
        bus.dec_valid = 1'b1;
        bus.dec_op = mk_op(5'd0, 5'd0, 5'd7, 1'b1, SRC1_ZERO, SRC2_IMM, 32'd5, 1'b0);
        @(negedge clk);
        chk("raw_first_accept", bus.dec_ready, 1'b1);
        tick();
        bus.dec_op = mk_op(5'd7, 5'd7, 5'd8, 1'b1, SRC1_RS1, SRC2_RS2, 32'd0, 1'b0);
        @(negedge clk);
        chk("raw_stall_1", bus.dec_ready, 1'b0);
        tick();
        @(negedge clk);
        chk("raw_stall_2", bus.dec_ready, 1'b0);
        tick();
        bus.wb_en = 1'b1;
        bus.wb_addr = 5'd7;
        bus.wb_data = 32'h0000_0010;
        @(negedge clk);
        chk("raw_release", bus.dec_ready, 1'b1);
        tick();
        bus.wb_en = 1'b0;
        bus.dec_valid = 1'b0;
        @(negedge clk);
        chk("raw_issue_valid", bus.issue_valid, 1'b1);
        chk("raw_bypass_in1", bus.alu_inputs.in1, 33'h0_0000_0010);
        chk("raw_bypass_in2", bus.alu_inputs.in2, 33'h0_0000_0010);
        tick();
        wb_write(5'd8, 32'h0000_0020);

        // Back-pressure for three cycles, then full throughput
        bus.issue_ready = 1'b0;
        bus.dec_valid = 1'b1;
        bus.dec_op = mk_op(5'd10, 5'd0, 5'd12, 1'b1, SRC1_RS1, SRC2_IMM, 32'h11, 1'b0);
        @(negedge clk);
        chk("bp_accept", bus.dec_ready, 1'b1);
        tick();
        bus.dec_op = mk_op(5'd11, 5'd0, 5'd13, 1'b1, SRC1_RS1, SRC2_IMM, 32'h22, 1'b0);
        @(negedge clk);
        snap = bus.alu_inputs;
        snap_rd = bus.issue_rd_addr;
        chk("bp_valid", bus.issue_valid, 1'b1);
        chk("bp_ready_low_0", bus.dec_ready, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("bp_hold_inputs", bus.alu_inputs, snap);
            chk("bp_hold_rd", bus.issue_rd_addr, snap_rd);
            chk("bp_ready_low", bus.dec_ready, 1'b0);
            tick();
        end
        bus.issue_ready = 1'b1;
        @(negedge clk);
        chk("bp_drain_accept", bus.dec_ready, 1'b1);
        tick();
        for (int k = 0; k < 2; k++) begin
            bus.dec_op = mk_op(5'd10, 5'd11, 5'(14 + k), 1'b1, SRC1_RS1, SRC2_RS2, 32'd0, 1'b0);
            @(negedge clk);
            chk("tput_ready", bus.dec_ready, 1'b1);
            chk("tput_valid", bus.issue_valid, 1'b1);
            tick();
        end
        bus.dec_valid = 1'b0;
        @(negedge clk);
        chk("tput_last_valid", bus.issue_valid, 1'b1);
        tick();

        // x0 destination sets nothing; x0 reader never stalls
        bus.dec_valid = 1'b1;
        bus.dec_op = mk_op(5'd0, 5'd0, 5'd0, 1'b1, SRC1_ZERO, SRC2_IMM, 32'd7, 1'b0);
        @(negedge clk);
        chk("x0_write_accept", bus.dec_ready, 1'b1);
        tick();
        bus.dec_op = mk_op(5'd0, 5'd0, 5'd0, 1'b0, SRC1_RS1, SRC2_RS2, 32'd0, 1'b0);
        @(negedge clk);
        chk("x0_no_stall", bus.dec_ready, 1'b1);
        tick();
        bus.dec_valid = 1'b0;
        @(negedge clk);
        chk("x0_in1", bus.alu_inputs.in1, 33'd0);
        chk("x0_in2", bus.alu_inputs.in2, 33'd0);
        tick();

        // Flush of a held op writing x9
        bus.issue_ready = 1'b0;
        bus.dec_valid = 1'b1;
        bus.dec_op = mk_op(5'd0, 5'd0, 5'd9, 1'b1, SRC1_ZERO, SRC2_IMM, 32'd9, 1'b0);
        @(negedge clk);
        chk("flush_op_accept", bus.dec_ready, 1'b1);
        tick();
        bus.dec_valid = 1'b0;
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_blocks_ready", bus.dec_ready, 1'b0);
        tick();
        bus.flush = 1'b0;
        bus.issue_ready = 1'b1;
        bus.dec_valid = 1'b1;
        bus.dec_op = mk_op(5'd9, 5'd9, 5'd0, 1'b0, SRC1_RS1, SRC2_RS2, 32'd0, 1'b0);
        @(negedge clk);
        chk("flush_valid_low", bus.issue_valid, 1'b0);
        chk("flush_x9_free", bus.dec_ready, 1'b1);
        tick();
        bus.dec_valid = 1'b0;
        @(negedge clk);
        chk("flush_x9_in1", bus.alu_inputs.in1, 33'd0);
        tick();

        // Reset with x3 pending and an op held
        wb_write(5'd3, 32'h0000_0033);
        bus.issue_ready = 1'b0;
        send(mk_op(5'd0, 5'd0, 5'd3, 1'b1, SRC1_ZERO, SRC2_IMM, 32'd1, 1'b0));
        rst = 1'b1;
        @(negedge clk);
        chk("rst2_dec_ready", bus.dec_ready, 1'b0);
        tick();
        @(negedge clk);
        chk("rst2_issue_valid", bus.issue_valid, 1'b0);
        chk("rst2_alu_inputs", bus.alu_inputs, 128'd0);
        chk("rst2_rd_addr", bus.issue_rd_addr, 5'd0);
        chk("rst2_rd_en", bus.issue_rd_en, 1'b0);
        tick();
        rst = 1'b0;
        bus.issue_ready = 1'b1;
        bus.dec_valid = 1'b1;
        bus.dec_op = mk_op(5'd3, 5'd3, 5'd0, 1'b0, SRC1_RS1, SRC2_RS2, 32'd0, 1'b0);
        @(negedge clk);
        chk("rst2_x3_free", bus.dec_ready, 1'b1);
        tick();
        bus.dec_valid = 1'b0;
        @(negedge clk);
        chk("rst2_x3_zero", bus.alu_inputs.in1, 33'd0);
        tick();

        repeat (3) tick();
        chk("sb_queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
